// File: rtl/cva6_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// cva6_mem_req_arbiter
//
// Shares the single cache-subsystem memory request channel between the
// I-cache refill path (requester 0) and the HPDcache miss/uncached path
// (requester 1). Requests are picked round-robin, tagged with the requester
// index in the upper transaction-ID bits and registered in a single-entry
// output stage. Outstanding transactions are counted per requester and
// responses are routed back combinationally by the upper TID bits.
//
// Optional feature macro: CVA6_MEM_ARB_PERF_EN
//   defined   -> one 32-bit stall counter per requester drives stall_cnt_o
//   undefined -> stall_cnt_o is tied to zero, no counter flops exist
// ---------------------------------------------------------------------------
module cva6_mem_req_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MEM_TID_W = 4,
    parameter int ADDR_W    = 64,
    parameter int PLD_W     = 128,
    parameter int RSP_W     = 128,
    parameter int MAX_OUTST = 7
) (
    input  logic                                                clk_i,
    input  logic                                                rst_ni,

    // requester side, request channel
    input  logic [NUM_REQ-1:0]                                  req_valid_i,
    output logic [NUM_REQ-1:0]                                  req_ready_o,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]                      req_addr_i,
    input  logic [NUM_REQ-1:0][PLD_W-1:0]                       req_pld_i,
    input  logic [NUM_REQ-1:0][MEM_TID_W-$clog2(NUM_REQ)-1:0]   req_tid_i,

    // memory side, request channel
    output logic                                                mem_req_valid_o,
    input  logic                                                mem_req_ready_i,
    output logic [ADDR_W-1:0]                                   mem_req_addr_o,
    output logic [PLD_W-1:0]                                    mem_req_pld_o,
    output logic [MEM_TID_W-1:0]                                mem_req_tid_o,

    // memory side, response channel
    input  logic                                                mem_rsp_valid_i,
    output logic                                                mem_rsp_ready_o,
    input  logic [MEM_TID_W-1:0]                                mem_rsp_tid_i,
    input  logic                                                mem_rsp_last_i,
    input  logic [RSP_W-1:0]                                    mem_rsp_pld_i,

    // requester side, response channel
    output logic [NUM_REQ-1:0]                                  rsp_valid_o,
    input  logic [NUM_REQ-1:0]                                  rsp_ready_i,
    output logic [MEM_TID_W-$clog2(NUM_REQ)-1:0]                rsp_tid_o,
    output logic                                                rsp_last_o,
    output logic [RSP_W-1:0]                                    rsp_pld_o,

    // status
    output logic [NUM_REQ-1:0][$clog2(MAX_OUTST+1)-1:0]         outst_o,
    output logic                                                err_o,
    output logic [NUM_REQ-1:0][31:0]                            stall_cnt_o
);

    localparam int IDX_W     = $clog2(NUM_REQ);
    localparam int REQ_TID_W = MEM_TID_W - IDX_W;
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]                r_rr;
    logic                            r_memReqValid;
    logic [ADDR_W-1:0]               r_memReqAddr;
    logic [PLD_W-1:0]                r_memReqPld;
    logic [MEM_TID_W-1:0]            r_memReqTid;
    logic [NUM_REQ-1:0][CNT_W-1:0]   r_outst;
    logic                            r_err;
    logic                            r_holdValid;
    logic [NUM_REQ-1:0]              r_holdGrant;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]              w_eligible;
    logic [NUM_REQ-1:0]              w_rrGrant;
    logic [NUM_REQ-1:0]              w_grant;
    logic                            w_loadOk;
    logic                            w_blocked;
    logic [NUM_REQ-1:0]              w_handshake;
    logic                            w_accept;
    logic [IDX_W-1:0]                w_accIdx;
    logic [IDX_W-1:0]                w_rspIdx;
    logic                            w_rspDone;
    logic [NUM_REQ-1:0]              w_inc;
    logic [NUM_REQ-1:0]              w_dec;
    logic                            w_underflow;

    // The output stage can take a new entry when it is empty or draining this cycle
    assign w_loadOk  = !r_memReqValid || mem_req_ready_i;
    assign w_blocked = r_memReqValid && !mem_req_ready_i;

    // A requester may compete only while it has room for another outstanding transaction
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = req_valid_i[i] && (r_outst[i] < MAX_CNT);
        end
    end

    // Round-robin search: first eligible requester at or after the pointer wins
    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             found;
        w_rrGrant = '0;
        cand      = r_rr;
        found     = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = r_rr + IDX_W'(off);
            if (!found && w_eligible[cand]) begin
                w_rrGrant[cand] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    // While the output stage is stalled the grant is frozen, so a completion that
    // frees a higher-priority requester cannot swap the winner under backpressure
    always_comb begin
        if (r_holdValid) begin
            w_grant = r_holdGrant & req_valid_i;
        end else begin
            w_grant = w_rrGrant;
        end
    end

    // Remember the grant seen during a stalled cycle so it is reused next cycle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_holdValid <= 1'b0;
            r_holdGrant <= '0;
        end else begin
            r_holdValid <= w_blocked && (|w_grant);
            r_holdGrant <= w_grant;
        end
    end

    // Ready is the grant qualified by room in the output stage, and is held low in reset
    assign req_ready_o = rst_ni ? (w_grant & {NUM_REQ{w_loadOk}}) : '0;
    assign w_handshake = req_valid_i & req_ready_o;
    assign w_accept    = |w_handshake;

    // Encode the accepted requester (one-hot handshake) into its index
    always_comb begin
        w_accIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_handshake[i]) begin
                w_accIdx = IDX_W'(i);
            end
        end
    end

    // Single-entry output register; reloads in the same cycle it drains
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_memReqValid <= 1'b0;
            r_memReqAddr  <= '0;
            r_memReqPld   <= '0;
            r_memReqTid   <= '0;
        end else if (w_loadOk) begin
            r_memReqValid <= w_accept;
            if (w_accept) begin
                r_memReqAddr <= req_addr_i[w_accIdx];
                r_memReqPld  <= req_pld_i[w_accIdx];
                r_memReqTid  <= {w_accIdx, req_tid_i[w_accIdx]};
            end
        end
    end

    assign mem_req_valid_o = r_memReqValid;
    assign mem_req_addr_o  = r_memReqAddr;
    assign mem_req_pld_o   = r_memReqPld;
    assign mem_req_tid_o   = r_memReqTid;

    // Move the round-robin pointer just past whoever was accepted; hold otherwise
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr <= '0;
        end else if (w_accept) begin
            r_rr <= w_accIdx + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Response path: purely combinational demux on the upper TID bits
    // ------------------------------------------------------------------
    assign w_rspIdx = mem_rsp_tid_i[MEM_TID_W-1 -: IDX_W];

    // Steer the response valid to its owner and take ready from that owner only
    always_comb begin
        rsp_valid_o           = '0;
        rsp_valid_o[w_rspIdx] = mem_rsp_valid_i;
        mem_rsp_ready_o       = rsp_ready_i[w_rspIdx];
    end

    assign rsp_tid_o  = mem_rsp_tid_i[REQ_TID_W-1:0];
    assign rsp_last_o = mem_rsp_last_i;
    assign rsp_pld_o  = mem_rsp_pld_i;

    assign w_rspDone = mem_rsp_valid_i && mem_rsp_ready_o && mem_rsp_last_i;

    // Per-requester increment/decrement strobes and detection of a completion with nothing outstanding
    always_comb begin
        w_inc       = '0;
        w_dec       = '0;
        w_underflow = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_inc[i] = w_handshake[i];
            w_dec[i] = w_rspDone && (w_rspIdx == IDX_W'(i));
            if (w_dec[i] && (r_outst[i] == '0)) begin
                w_underflow = 1'b1;
            end
        end
    end

    // Outstanding counters; a completion at zero is ignored so the count saturates
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_outst <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_dec[i] && (r_outst[i] == '0)) begin
                    if (w_inc[i]) begin
                        r_outst[i] <= r_outst[i] + CNT_W'(1);
                    end
                end else if (w_inc[i] && !w_dec[i]) begin
                    r_outst[i] <= r_outst[i] + CNT_W'(1);
                end else if (!w_inc[i] && w_dec[i]) begin
                    r_outst[i] <= r_outst[i] - CNT_W'(1);
                end
            end
        end
    end

    assign outst_o = r_outst;

    // Sticky protocol error flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_underflow) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

`ifdef CVA6_MEM_ARB_PERF_EN
    logic [NUM_REQ-1:0][31:0] r_stallCnt;

    // Count cycles each requester waits with valid high and no acceptance; wraps naturally
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stallCnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid_i[i] && !req_ready_o[i]) begin
                    r_stallCnt[i] <= r_stallCnt[i] + 32'd1;
                end
            end
        end
    end

    assign stall_cnt_o = r_stallCnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cva6_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// Directed testbench for cva6_mem_req_arbiter (default parameters:
// 2 requesters, 4-bit memory TID, 3-bit requester TID, MAX_OUTST = 7).
// Honours CVA6_MEM_ARB_PERF_EN for the stall-counter expectations.
// ---------------------------------------------------------------------------
module tb_cva6_mem_req_arbiter;

    logic                  clk = 1'b0;
    logic                  rstN;
    logic [1:0]            reqValid;
    logic [1:0]            reqReady;
    logic [1:0][63:0]      reqAddr;
    logic [1:0][127:0]     reqPld;
    logic [1:0][2:0]       reqTid;
    logic                  memReqValid;
    logic                  memReqReady;
    logic [63:0]           memReqAddr;
    logic [127:0]          memReqPld;
    logic [3:0]            memReqTid;
    logic                  memRspValid;
    logic                  memRspReady;
    logic [3:0]            memRspTid;
    logic                  memRspLast;
    logic [127:0]          memRspPld;
    logic [1:0]            rspValid;
    logic [1:0]            rspReady;
    logic [2:0]            rspTid;
    logic                  rspLast;
    logic [127:0]          rspPld;
    logic [1:0][2:0]       outst;
    logic                  err;
    logic [1:0][31:0]      stallCnt;

    int totalChecks = 0;
    int badChecks   = 0;

    // free-running clock, 10 time units per period
    always #5 clk = ~clk;

    cva6_mem_req_arbiter dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .req_valid_i     (reqValid),
        .req_ready_o     (reqReady),
        .req_addr_i      (reqAddr),
        .req_pld_i       (reqPld),
        .req_tid_i       (reqTid),
        .mem_req_valid_o (memReqValid),
        .mem_req_ready_i (memReqReady),
        .mem_req_addr_o  (memReqAddr),
        .mem_req_pld_o   (memReqPld),
        .mem_req_tid_o   (memReqTid),
        .mem_rsp_valid_i (memRspValid),
        .mem_rsp_ready_o (memRspReady),
        .mem_rsp_tid_i   (memRspTid),
        .mem_rsp_last_i  (memRspLast),
        .mem_rsp_pld_i   (memRspPld),
        .rsp_valid_o     (rspValid),
        .rsp_ready_i     (rspReady),
        .rsp_tid_o       (rspTid),
        .rsp_last_o      (rspLast),
        .rsp_pld_o       (rspPld),
        .outst_o         (outst),
        .err_o           (err),
        .stall_cnt_o     (stallCnt)
    );

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // hold reset for two edges with all inputs idle, release just after an edge
    task automatic doReset();
        rstN        = 1'b0;
        reqValid    = 2'b00;
        memReqReady = 1'b0;
        memRspValid = 1'b0;
        memRspLast  = 1'b0;
        memRspTid   = 4'h0;
        rspReady    = 2'b00;
        tick();
        tick();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN        = 1'b0;
        reqValid    = 2'b11;
        memReqReady = 1'b1;
        memRspValid = 1'b0;
        memRspLast  = 1'b0;
        memRspTid   = 4'h0;
        memRspPld   = '0;
        rspReady    = 2'b00;
        reqAddr     = '0;
        reqPld      = '0;
        reqTid      = '0;
        tick();
        tick();
        #1;
        totalChecks++;
        if (reqReady !== 2'b00) begin
            $display("[TB] FAIL reset_ready: got %b want 00", reqReady); badChecks++;
        end
        totalChecks++;
        if (memReqValid !== 1'b0) begin
            $display("[TB] FAIL reset_valid: got %b want 0", memReqValid); badChecks++;
        end
        totalChecks++;
        if (memReqTid !== 4'h0 || memReqAddr !== 64'h0 || memReqPld !== 128'h0) begin
            $display("[TB] FAIL reset_payload: tid %h addr %h want zeros", memReqTid, memReqAddr); badChecks++;
        end
        totalChecks++;
        if (outst !== 6'b0) begin
            $display("[TB] FAIL reset_outst: got %h want 0", outst); badChecks++;
        end
        totalChecks++;
        if (err !== 1'b0) begin
            $display("[TB] FAIL reset_err: got %b want 0", err); badChecks++;
        end
        totalChecks++;
        if (stallCnt !== 64'h0) begin
            $display("[TB] FAIL reset_stall: got %h want 0", stallCnt); badChecks++;
        end
        reqValid    = 2'b00;
        memReqReady = 1'b0;
        tick();
        rstN = 1'b1;
    endtask

    task automatic test_single();
        memReqReady = 1'b1;
        reqAddr[0]  = 64'h8000_0040;
        reqPld[0]   = 128'hC0FFEE;
        reqTid[0]   = 3'd3;
        reqValid    = 2'b01;
        #1;
        totalChecks++;
        if (reqReady !== 2'b01) begin
            $display("[TB] FAIL single_ready: got %b want 01", reqReady); badChecks++;
        end
        tick();
        reqValid = 2'b00;
        totalChecks++;
        if (memReqValid !== 1'b1 || memReqTid !== 4'h3) begin
            $display("[TB] FAIL single_issue: valid %b tid %h want 1 3", memReqValid, memReqTid); badChecks++;
        end
        totalChecks++;
        if (memReqAddr !== 64'h8000_0040 || memReqPld !== 128'hC0FFEE) begin
            $display("[TB] FAIL single_payload: addr %h pld %h want 80000040 c0ffee", memReqAddr, memReqPld); badChecks++;
        end
        totalChecks++;
        if (outst[0] !== 3'd1) begin
            $display("[TB] FAIL single_outst: got %0d want 1", outst[0]); badChecks++;
        end
        tick();
        totalChecks++;
        if (memReqValid !== 1'b0) begin
            $display("[TB] FAIL single_drain: got %b want 0", memReqValid); badChecks++;
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  expReady;
        logic [3:0]  expTid;
        logic [63:0] expAddr;
        doReset();
        memReqReady = 1'b1;
        reqTid[0]   = 3'd1;
        reqTid[1]   = 3'd2;
        reqAddr[0]  = 64'h1000;
        reqAddr[1]  = 64'h2000;
        reqValid    = 2'b11;
        for (int k = 0; k < 4; k++) begin
            expReady = (k % 2 == 0) ? 2'b01 : 2'b10;
            expTid   = (k % 2 == 0) ? 4'h1 : 4'hA;
            expAddr  = (k % 2 == 0) ? 64'h1000 : 64'h2000;
            #1;
            totalChecks++;
            if (reqReady !== expReady) begin
                $display("[TB] FAIL rr_grant%0d: got %b want %b", k, reqReady, expReady); badChecks++;
            end
            tick();
            totalChecks++;
            if (memReqValid !== 1'b1 || memReqTid !== expTid || memReqAddr !== expAddr) begin
                $display("[TB] FAIL rr_issue%0d: valid %b tid %h addr %h want 1 %h %h",
                         k, memReqValid, memReqTid, memReqAddr, expTid, expAddr); badChecks++;
            end
        end
        reqValid = 2'b00;
        totalChecks++;
        if (outst[0] !== 3'd2 || outst[1] !== 3'd2) begin
            $display("[TB] FAIL rr_outst: got %0d %0d want 2 2", outst[0], outst[1]); badChecks++;
        end
    endtask

    task automatic test_backpressure();
        doReset();
        memReqReady = 1'b1;
        reqTid[0]   = 3'd5;
        reqTid[1]   = 3'd6;
        reqAddr[0]  = 64'hA0;
        reqAddr[1]  = 64'hB0;
        reqPld[0]   = 128'h111;
        reqPld[1]   = 128'h222;
        reqValid    = 2'b11;
        #1;
        totalChecks++;
        if (reqReady !== 2'b01) begin
            $display("[TB] FAIL bp_first_ready: got %b want 01", reqReady); badChecks++;
        end
        tick();
        memReqReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            totalChecks++;
            if (reqReady !== 2'b00) begin
                $display("[TB] FAIL bp_ready%0d: got %b want 00", k, reqReady); badChecks++;
            end
            tick();
            totalChecks++;
            if (memReqValid !== 1'b1 || memReqTid !== 4'h5 || memReqAddr !== 64'hA0 || memReqPld !== 128'h111) begin
                $display("[TB] FAIL bp_hold%0d: valid %b tid %h addr %h pld %h want 1 5 a0 111",
                         k, memReqValid, memReqTid, memReqAddr, memReqPld); badChecks++;
            end
        end
`ifdef CVA6_MEM_ARB_PERF_EN
        totalChecks++;
        if (stallCnt[0] !== 32'd5 || stallCnt[1] !== 32'd6) begin
            $display("[TB] FAIL bp_stall_mid: got %0d %0d want 5 6", stallCnt[0], stallCnt[1]); badChecks++;
        end
`else
        totalChecks++;
        if (stallCnt !== 64'h0) begin
            $display("[TB] FAIL bp_stall_off: got %h want 0", stallCnt); badChecks++;
        end
`endif
        memReqReady = 1'b1;
        #1;
        totalChecks++;
        if (reqReady !== 2'b10) begin
            $display("[TB] FAIL bp_release_ready: got %b want 10", reqReady); badChecks++;
        end
        tick();
        reqValid = 2'b00;
        totalChecks++;
        if (memReqValid !== 1'b1 || memReqTid !== 4'hE || memReqAddr !== 64'hB0 || memReqPld !== 128'h222) begin
            $display("[TB] FAIL bp_release_issue: valid %b tid %h addr %h want 1 e b0",
                     memReqValid, memReqTid, memReqAddr); badChecks++;
        end
`ifdef CVA6_MEM_ARB_PERF_EN
        totalChecks++;
        if (stallCnt[0] !== 32'd6 || stallCnt[1] !== 32'd6) begin
            $display("[TB] FAIL bp_stall_end: got %0d %0d want 6 6", stallCnt[0], stallCnt[1]); badChecks++;
        end
`endif
    endtask

    task automatic test_outst_limit();
        doReset();
        memReqReady = 1'b1;
        reqTid[1]   = 3'd2;
        reqAddr[1]  = 64'h3000;
        reqValid    = 2'b10;
        for (int k = 0; k < 7; k++) begin
            #1;
            totalChecks++;
            if (reqReady !== 2'b10) begin
                $display("[TB] FAIL lim_accept%0d: got %b want 10", k, reqReady); badChecks++;
            end
            tick();
        end
        #1;
        totalChecks++;
        if (reqReady !== 2'b00 || outst[1] !== 3'd7) begin
            $display("[TB] FAIL lim_full: ready %b outst %0d want 00 7", reqReady, outst[1]); badChecks++;
        end
        reqValid = 2'b11;
        #1;
        totalChecks++;
        if (reqReady !== 2'b01) begin
            $display("[TB] FAIL lim_other_granted: got %b want 01", reqReady); badChecks++;
        end
        reqValid    = 2'b10;
        memRspPld   = 128'h5A5A;
        memRspTid   = 4'hA;
        memRspLast  = 1'b1;
        rspReady    = 2'b10;
        memRspValid = 1'b1;
        #1;
        totalChecks++;
        if (rspValid !== 2'b10 || rspTid !== 3'd2 || memRspReady !== 1'b1 || rspLast !== 1'b1 || rspPld !== 128'h5A5A) begin
            $display("[TB] FAIL lim_rsp_route: valid %b tid %0d ready %b last %b want 10 2 1 1",
                     rspValid, rspTid, memRspReady, rspLast); badChecks++;
        end
        tick();
        memRspValid = 1'b0;
        memRspLast  = 1'b0;
        #1;
        totalChecks++;
        if (outst[1] !== 3'd6 || reqReady !== 2'b10) begin
            $display("[TB] FAIL lim_release: outst %0d ready %b want 6 10", outst[1], reqReady); badChecks++;
        end
    endtask

    task automatic test_rsp_routing();
        reqValid    = 2'b00;
        memRspTid   = 4'h9;
        memRspLast  = 1'b0;
        rspReady    = 2'b01;
        memRspValid = 1'b1;
        #1;
        totalChecks++;
        if (rspValid !== 2'b10 || rspTid !== 3'd1 || memRspReady !== 1'b0) begin
            $display("[TB] FAIL route_demux: valid %b tid %0d ready %b want 10 1 0",
                     rspValid, rspTid, memRspReady); badChecks++;
        end
        rspReady   = 2'b10;
        memRspLast = 1'b1;
        reqValid   = 2'b10;
        #1;
        totalChecks++;
        if (memRspReady !== 1'b1 || reqReady !== 2'b10) begin
            $display("[TB] FAIL route_simul: rspready %b reqready %b want 1 10", memRspReady, reqReady); badChecks++;
        end
        tick();
        memRspValid = 1'b0;
        memRspLast  = 1'b0;
        reqValid    = 2'b00;
        totalChecks++;
        if (outst[1] !== 3'd6) begin
            $display("[TB] FAIL route_outst_same: got %0d want 6", outst[1]); badChecks++;
        end
        totalChecks++;
        if (memReqValid !== 1'b1 || memReqTid !== 4'hA) begin
            $display("[TB] FAIL route_issue: valid %b tid %h want 1 a", memReqValid, memReqTid); badChecks++;
        end
    endtask

    task automatic test_error_reset();
        memReqReady = 1'b0;
        memRspTid   = 4'h2;
        memRspLast  = 1'b1;
        rspReady    = 2'b01;
        memRspValid = 1'b1;
        #1;
        totalChecks++;
        if (rspValid !== 2'b01 || memRspReady !== 1'b1) begin
            $display("[TB] FAIL err_route: valid %b ready %b want 01 1", rspValid, memRspReady); badChecks++;
        end
        tick();
        memRspValid = 1'b0;
        memRspLast  = 1'b0;
        totalChecks++;
        if (err !== 1'b1 || outst[0] !== 3'd0) begin
            $display("[TB] FAIL err_set: err %b outst %0d want 1 0", err, outst[0]); badChecks++;
        end
        totalChecks++;
        if (memReqValid !== 1'b1) begin
            $display("[TB] FAIL err_pending: got %b want 1", memReqValid); badChecks++;
        end
        rstN     = 1'b0;
        reqValid = 2'b01;
        #1;
        totalChecks++;
        if (reqReady !== 2'b00) begin
            $display("[TB] FAIL err_rst_ready: got %b want 00", reqReady); badChecks++;
        end
        tick();
        totalChecks++;
        if (memReqValid !== 1'b0 || err !== 1'b0 || outst[1] !== 3'd0 || memReqTid !== 4'h0) begin
            $display("[TB] FAIL err_rst_clear: valid %b err %b outst %0d tid %h want 0 0 0 0",
                     memReqValid, err, outst[1], memReqTid); badChecks++;
        end
        reqValid = 2'b00;
        rstN     = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_outst_limit();
        test_rsp_routing();
        test_error_reset();
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/cva6_mem_req_arbiter.md
# cva6_mem_req_arbiter

Round-robin arbiter that shares the single cache-subsystem memory request channel between the instruction-cache refill path and the HPDcache miss/uncached path. It tags each request with the requester index in the upper transaction-ID bits and registers the winning request. It tracks outstanding transactions per requester and demultiplexes responses back by transaction ID. It sits between the cache requesters and the AXI adapter in the HPDcache subsystem.

## Interface
- NUM_REQ, 2: number of requesters; index 0 = I-cache, 1 = D-cache; power of two, ≥2.
- MEM_TID_W, 4: memory-side transaction ID width.
- REQ_TID_W, MEM_TID_W − $clog2(NUM_REQ): requester-side TID width; derived, not overridable.
- ADDR_W, 64: request address width.
- PLD_W, 128: opaque request payload width, covering data, size, command and atop.
- RSP_W, 128: opaque response payload width.
- MAX_OUTST, 7: maximum outstanding transactions per requester; the counter width is $clog2(MAX_OUTST+1).
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester request accepted.
- req_addr_i  in  NUM_REQ×ADDR_W  request address.
- req_pld_i  in  NUM_REQ×PLD_W  request payload.
- req_tid_i  in  NUM_REQ×REQ_TID_W  requester TID.
- mem_req_valid_o  out  1  registered request valid.
- mem_req_ready_i  in  1  memory side accepts.
- mem_req_addr_o / mem_req_pld_o / mem_req_tid_o  out  ADDR_W / PLD_W / MEM_TID_W  registered request; tid = {index, req_tid}.
- mem_rsp_valid_i  in  1  response valid.
- mem_rsp_ready_o  out  1  response accepted.
- mem_rsp_tid_i  in  MEM_TID_W  response TID.
- mem_rsp_last_i  in  1  final beat of the transaction.
- mem_rsp_pld_i  in  RSP_W  response payload.
- rsp_valid_o  out  NUM_REQ  per-requester response valid.
- rsp_ready_i  in  NUM_REQ  per-requester response ready.
- rsp_tid_o / rsp_last_o / rsp_pld_o  out  REQ_TID_W / 1 / RSP_W  broadcast to all requesters, qualified by rsp_valid_o.
- outst_o  out  NUM_REQ×cnt  outstanding count per requester.
- err_o  out  1  sticky: response received for a requester whose outstanding count is 0.
- stall_cnt_o  out  NUM_REQ×32  cycles with valid high and ready low; present only with the macro.

## Operation
- Eligibility: requester i is eligible when req_valid_i[i] is high and outst[i] < MAX_OUTST.
- Selection: round-robin over eligible requesters, starting at pointer rr. rr resets to 0.
- Pointer update: after an accepted request from requester k, rr becomes (k+1) mod NUM_REQ. rr holds when nothing is accepted.
- Output register: a single-entry register. It can load when it is empty, or when mem_req_valid_o and mem_req_ready_i are both high in the same cycle (full throughput, no bubble).
- Acceptance: req_ready_o[k] = grant[k] & load_ok. At most one bit is high. req_ready_o does not depend on req_valid_i of other requesters except through grant.
- Request handshake: occurs when req_valid_i[k] and req_ready_o[k] are both high. The address, payload and {k, tid} are captured. outst[k] increments.
- Response routing: index j = mem_rsp_tid_i[MEM_TID_W-1 -: log2(NUM_REQ)]. rsp_valid_o[j] = mem_rsp_valid_i. mem_rsp_ready_o = rsp_ready_i[j]. The lower TID bits drive rsp_tid_o. The path is combinational.
- Response completion: a response handshake with mem_rsp_last_i high decrements outst[j].
- Simultaneous increment and decrement on the same requester: the count is unchanged.
- Completion at count 0: no decrement (saturates at 0) and err_o sets. err_o clears only on reset.
- The grant never changes while the output register is blocked. A request whose valid was seen with ready low must stay stable; the arbiter does not check this.

## Timing
- Latency: a request accepted in cycle N appears on mem_req_valid_o in cycle N+1. The response path has 0 cycles of latency.
- Throughput: 1 request per cycle while mem_req_ready_i is held high.
- Reset values: mem_req_valid_o=0, the mem_req payload registers are 0, rr=0, all outst=0, err_o=0, stall counters 0.
- During reset req_ready_o is 0. rsp_valid_o follows mem_rsp_valid_i; the environment keeps mem_rsp_valid_i low during reset.
- Reset mid-operation: the pending output entry is dropped and all counts clear. No response drain is performed.

## Configuration
- Macro: CVA6_MEM_ARB_PERF_EN.
- Defined: one 32-bit stall counter per requester, which increments on each cycle with req_valid_i[i] high and req_ready_o[i] low. The counter wraps at 2^32 and clears on reset.
- Undefined: stall_cnt_o is tied to 0 and no counter flops are synthesized.

## Test plan
- Single request: req_valid_i=2'b01, addr 0x8000_0040, tid 3 → ready[0] high the same cycle; one cycle later mem_req_valid_o=1, mem_req_tid_o=4'h3. outst[0]=1.
- Round-robin fairness: both requesters valid continuously, mem_req_ready_i=1 → grants alternate 0,1,0,1 with one request issued per cycle.
- Backpressure: mem_req_ready_i=0 for 5 cycles with both requesters valid → the register holds, req_ready_o=0, and the payload stays stable. On release, the next request loads in the same cycle.
- Outstanding limit: 7 requests from the D-cache with no responses → ready[1]=0 while requester 0 is still granted. Completion with tid 4'hA and last=1 → outst[1]=6 and ready[1] is allowed again.
- Response routing: mem_rsp tid 4'h9, rsp_ready_i=2'b01 → rsp_valid_o=2'b10, rsp_tid_o=1, mem_rsp_ready_o=0. Completion then occurs at the same time as a new D-cache accept → outst[1] is unchanged.
- Error and reset: response with last=1 for requester 0 while outst[0]=0 → err_o=1. Applying rst_ni=0 while a request is pending → the next cycle mem_req_valid_o=0 and err_o=0. With CVA6_MEM_ARB_PERF_EN, 5 blocked cycles → stall_cnt_o=5.
